pipeline_hazard_ctrl: RTL



---
 rtl/pipeline_hazard_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: stalls, flushes, forwarding, memory-wait FSM.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_CW       = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              ResultSrcE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              PCSrcE,
    input  logic              MemReqM,
    input  logic              MemAckM,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              BubbleW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              MemErr
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       PerfMemStall,
    output logic [31:0]       PerfLoadUse,
    output logic [31:0]       PerfFlush
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

    state_t           state_q, state_d;
    logic [TO_CW-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic             memstall;
    logic             lu;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_m,
        input logic              we_w
    );
        if (we_m && (rd_m != '0) && (rd_m == rs))
            return 2'b10;
        else if (we_w && (rd_w != '0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            S_IDLE: begin
                if (MemReqM && !MemAckM) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end
            end
            S_WAIT: begin
                if (MemAckM) begin
                    state_d = S_IDLE;
                end else if (wait_cnt_q == TO_CW'(MEM_TIMEOUT - 1)) begin
                    state_d   = S_ERR;
                    mem_err_d = 1'b1;
                end else begin
                    // Only counts below the timeout limit, so it saturates instead of wrapping.
                    wait_cnt_d = wait_cnt_q + TO_CW'(1);
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign memstall = (state_q == S_ERR) ||
                      (!MemAckM && ((state_q == S_WAIT) || ((state_q == S_IDLE) && MemReqM)));
    assign lu       = ResultSrcE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign MemErr   = mem_err_q;

    // Outputs are gated by rst_n so nothing leaks from live inputs while reset is held.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        BubbleW   = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (rst_n) begin
            if (memstall) begin
                StallF  = 1'b1;
                StallD  = 1'b1;
                StallE  = 1'b1;
                StallM  = 1'b1;
                BubbleW = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lu) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
            ForwardAE = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
            ForwardBE = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_ms_q, perf_ms_d;
    logic [31:0] perf_lu_q, perf_lu_d;
    logic [31:0] perf_fl_q, perf_fl_d;

    always_comb begin
        perf_ms_d = perf_ms_q;
        perf_lu_d = perf_lu_q;
        perf_fl_d = perf_fl_q;
        if (memstall)
            perf_ms_d = perf_ms_q + 32'd1;
        else if (PCSrcE)
            perf_fl_d = perf_fl_q + 32'd1;
        else if (lu)
            perf_lu_d = perf_lu_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ms_q <= '0;
            perf_lu_q <= '0;
            perf_fl_q <= '0;
        end else begin
            perf_ms_q <= perf_ms_d;
            perf_lu_q <= perf_lu_d;
            perf_fl_q <= perf_fl_d;
        end
    end

    assign PerfMemStall = perf_ms_q;
    assign PerfLoadUse  = perf_lu_q;
    assign PerfFlush    = perf_fl_q;
`endif

endmodule
